// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: shared widths, access-size codes and LSU state encodings
package mem_stage_lsu_pkg;
    localparam int WIDTH = 32;
    localparam int R_WIDTH = 5;
    localparam int WB_CTRL_WIDTH = 2;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_BUSY = 2'b01,
        LSU_DONE = 2'b10
    } lsu_state_e;
endpackage

// File: rtl/mem_stage_lsu_lane_format.sv
// lsu_lane_format: store lane steering / byte enables and load lane extraction / extension
module lsu_lane_format
    import mem_stage_lsu_pkg::*;
(
    input  logic [1:0]       st_size,
    input  logic [1:0]       st_addr,
    input  logic [WIDTH-1:0] st_data,
    output logic [3:0]       st_be,
    output logic [WIDTH-1:0] st_lanes,
    input  logic [1:0]       ld_size,
    input  logic [1:0]       ld_addr,
    input  logic             ld_uns,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] ld_result
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    always_comb begin
        st_be    = st_size == SZ_BYTE ? 4'b0001 << st_addr :
                   st_size == SZ_HALF ? (st_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        st_lanes = st_size == SZ_BYTE ? {4{st_data[7:0]}} :
                   st_size == SZ_HALF ? {2{st_data[15:0]}} : st_data;
        ld_byte   = ld_data[{ld_addr, 3'b000} +: 8];
        ld_half   = ld_addr[1] ? ld_data[31:16] : ld_data[15:0];
        ld_result = ld_size == SZ_BYTE ? {{(WIDTH-8){~ld_uns & ld_byte[7]}}, ld_byte} :
                    ld_size == SZ_HALF ? {{(WIDTH-16){~ld_uns & ld_half[15]}}, ld_half} : ld_data;
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit on a multi-cycle data bus; LSU_ALIGN_CHECK_EN traps misaligned accesses
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             mem_read_i,
    input  logic             mem_write_i,
    input  logic [1:0]       size_i,
    input  logic             unsigned_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             dbus_req_o,
    output logic             dbus_we_o,
    output logic [WIDTH-1:0] dbus_addr_o,
    output logic [3:0]       dbus_be_o,
    output logic [WIDTH-1:0] dbus_wdata_o,
    input  logic [WIDTH-1:0] dbus_rdata_i,
    input  logic             dbus_ack_i,
    output logic [WIDTH-1:0] read_data_o,
    output logic             stall_o,
    output logic             err_o
);
    localparam int CW = $clog2(BUS_TIMEOUT + 1);
    lsu_state_e       state, state_d;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] addr_q, wdata_q, wdata_st, rdata_fmt;
    logic [3:0]       be_q, be_st;
    logic [1:0]       size_q;
    logic             we_q, uns_q, err_q;
    logic             access, misaligned, ack, timeout;
    assign access  = mem_read_i | mem_write_i;
    assign ack     = state == LSU_BUSY && dbus_ack_i;
    assign timeout = state == LSU_BUSY && cnt == CW'(BUS_TIMEOUT - 1);
`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = (size_i == SZ_HALF && addr_i[0]) || (size_i[1] && addr_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif
    lsu_lane_format u_fmt (
        .st_size   (size_i),
        .st_addr   (addr_i[1:0]),
        .st_data   (wdata_i),
        .st_be     (be_st),
        .st_lanes  (wdata_st),
        .ld_size   (size_q),
        .ld_addr   (addr_q[1:0]),
        .ld_uns    (uns_q),
        .ld_data   (dbus_rdata_i),
        .ld_result (rdata_fmt)
    );
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= LSU_IDLE;
        else          state <= state_d;
    end
    always_comb begin
        state_d = state == LSU_IDLE ? (access ? (misaligned ? LSU_DONE : LSU_BUSY) : LSU_IDLE) :
                  state == LSU_BUSY ? (dbus_ack_i || timeout ? LSU_DONE : LSU_BUSY) : LSU_IDLE;
    end
    always_comb begin
        dbus_req_o   = state == LSU_BUSY;
        stall_o      = (state == LSU_IDLE && access) || state == LSU_BUSY;
        dbus_we_o    = we_q;
        dbus_addr_o  = {addr_q[WIDTH-1:2], 2'b00};
        dbus_be_o    = be_q;
        dbus_wdata_o = wdata_q;
        err_o        = err_q;
    end
    // err_q is only ever set on the way into DONE, so it is high for that cycle alone
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            err_q       <= 1'b0;
            read_data_o <= '0;
        end else begin
            err_q <= 1'b0;
            cnt   <= state == LSU_BUSY ? cnt + 1'b1 : '0;
            if (state == LSU_IDLE && access) begin
                addr_q  <= addr_i;
                be_q    <= be_st;
                wdata_q <= wdata_st;
                we_q    <= mem_write_i;
                size_q  <= size_i;
                uns_q   <= unsigned_i;
                if (misaligned) begin
                    err_q       <= 1'b1;
                    read_data_o <= '0;
                end
            end
            if (ack) begin
                read_data_o <= we_q ? '0 : rdata_fmt;
            end else if (timeout) begin
                read_data_o <= '0;
                err_q       <= 1'b1;
            end
        end
    end
endmodule
